// File: rtl/uart_key_scheduler.sv
// rtl/uart_key_scheduler.sv - queues UART key bytes and replays each as a fixed-length one-hot button press
// Optional: define UART_KEY_FLUSH_EN so ESC (8'h1B) flushes the queue and cuts the current press short.
module uart_key_scheduler #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 2_500_000,
  parameter int GAP_CYCLES  = 250_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic                     btnUp,
  output logic                     btnDown,
  output logic                     btnLeft,
  output logic                     btnRight,
  output logic                     btnAttack,
  output logic                     busy,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_level
);
  localparam int AW   = $clog2(DEPTH);
  localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

  logic          keyValid;
  logic [2:0]    keyCode;
  logic          escSeen;
  logic [2:0]    mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [AW:0]   level;
  logic          fifoEmpty, fifoFull, push, pop, drop;
  state_t        state, nextState;
  logic [CW-1:0] count, nextCount;
  logic [2:0]    curCode, nextCode;
  logic [4:0]    btns, nextBtns;

  // Codes index the button vector: Up, Down, Left, Right, Attack.
  always_comb begin
    keyValid = 1'b1;
    keyCode  = 3'd0;
    case (rx_data)
      8'h77:   keyCode = 3'd0;
      8'h73:   keyCode = 3'd1;
      8'h61:   keyCode = 3'd2;
      8'h64:   keyCode = 3'd3;
      8'h20:   keyCode = 3'd4;
      default: keyValid = 1'b0;
    endcase
  end

`ifdef UART_KEY_FLUSH_EN
  assign escSeen = rx_valid && (rx_data == 8'h1B);
`else
  assign escSeen = 1'b0;
`endif

  assign fifoEmpty = (level == '0);
  assign fifoFull  = (level == (AW+1)'(DEPTH));
  // A flush suppresses the pop so the flushed head is never started.
  assign pop       = (state == IDLE) && !fifoEmpty && !escSeen;
  assign push      = rx_valid && keyValid && (!fifoFull || pop);
  assign drop      = rx_valid && keyValid && fifoFull && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= drop;
      if (escSeen) begin
        wrPtr <= '0;
        rdPtr <= '0;
        level <= '0;
      end else begin
        if (push) wrPtr <= wrPtr + AW'(1);
        if (pop)  rdPtr <= rdPtr + AW'(1);
        level <= level + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= keyCode;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      curCode <= 3'd0;
      btns    <= '0;
    end else begin
      state   <= nextState;
      count   <= nextCount;
      curCode <= nextCode;
      btns    <= nextBtns;
    end
  end

  always_comb begin
    nextState = state;
    nextCount = count;
    nextCode  = curCode;
    case (state)
      IDLE: begin
        if (pop) begin
          nextState = PRESS;
          nextCount = HOLD_LOAD;
          nextCode  = mem[rdPtr];
        end
      end
      PRESS: begin
        if (count == '0 || escSeen) begin
          nextState = (GAP_CYCLES == 0) ? IDLE : GAP;
          nextCount = GAP_LOAD;
        end else begin
          nextCount = count - CW'(1);
        end
      end
      GAP: begin
        if (count == '0) nextState = IDLE;
        else             nextCount = count - CW'(1);
      end
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    nextBtns = '0;
    if (nextState == PRESS) nextBtns = 5'(5'b1 << nextCode);
  end

  assign btnUp      = btns[0];
  assign btnDown    = btns[1];
  assign btnLeft    = btns[2];
  assign btnRight   = btns[3];
  assign btnAttack  = btns[4];
  assign busy       = (state != IDLE) || !fifoEmpty;
  assign fifo_level = level;
endmodule

// File: tb/tb_uart_key_scheduler.sv
// tb/tb_uart_key_scheduler.sv - bench for uart_key_scheduler against a press-window reference model
`timescale 1ns/1ps
module tb_uart_key_scheduler;
  localparam int DEPTH = 4;
  localparam int HOLD  = 8;
  localparam int GAP   = 4;
`ifdef UART_KEY_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       btnUp, btnDown, btnLeft, btnRight, btnAttack;
  logic       busy, overflow;
  logic [2:0] fifo_level;

  uart_key_scheduler #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .btnUp(btnUp), .btnDown(btnDown), .btnLeft(btnLeft), .btnRight(btnRight),
    .btnAttack(btnAttack), .busy(busy), .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int nCmp = 0;
  int nFail = 0;
  int cyc = 0;
  logic [7:0] keys [5] = '{8'h77, 8'h73, 8'h61, 8'h64, 8'h20};
  logic [7:0] burst [6] = '{8'h61, 8'h73, 8'h64, 8'h20, 8'h61, 8'h73};

  // Model: a queue of codes plus the absolute cycle window of the current press.
  int q[$];
  int pressStart = -1;
  int pressEnd = -2;
  int idleAt = 0;
  int curCode = 0;
  bit ovExp = 1'b0;
  bit modelValid = 1'b0;

  function automatic int keyIdx(input logic [7:0] d);
    for (int i = 0; i < 5; i++) if (keys[i] == d) return i;
    return -1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    nCmp++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) begin
    int k;
    bit esc, popNow;
    if (rst) begin
      q.delete();
      pressStart = -1;
      pressEnd = -2;
      idleAt = cyc + 1;
      ovExp = 1'b0;
      modelValid = 1'b1;
    end else begin
      esc = FLUSH && rx_valid && (rx_data == 8'h1B);
      k = rx_valid ? keyIdx(rx_data) : -1;
      popNow = (cyc >= idleAt) && (q.size() > 0) && !esc;
      ovExp = 1'b0;
      if (popNow) begin
        curCode = q.pop_front();
        pressStart = cyc + 1;
        pressEnd = cyc + HOLD;
        idleAt = cyc + HOLD + GAP + 1;
      end
      if (esc) begin
        q.delete();
        if (cyc >= pressStart && cyc <= pressEnd) begin
          pressEnd = cyc;
          idleAt = cyc + 1 + GAP;
        end
      end
      if (k >= 0) begin
        if (q.size() < DEPTH) q.push_back(k);
        else ovExp = 1'b1;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    int expBtn;
    if (modelValid) begin
      expBtn = (cyc >= pressStart && cyc <= pressEnd) ? (1 << curCode) : 0;
      chk("btns", int'({btnAttack, btnRight, btnLeft, btnDown, btnUp}), expBtn);
      chk("busy", busy, int'((cyc < idleAt) || (q.size() > 0)));
      chk("overflow", overflow, int'(ovExp));
      chk("fifo_level", fifo_level, q.size());
    end
  end

  task automatic drive(input logic r, input logic v, input logic [7:0] d);
    rst = r;
    rx_valid = v;
    rx_data = d;
    @(negedge clk);
  endtask

  task automatic idleUntil(input int c);
    while (cyc < c) drive(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    logic [7:0] d;
    @(negedge clk);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    chk("reset_btns", int'({btnAttack, btnRight, btnLeft, btnDown, btnUp}), 0);
    chk("reset_busy", busy, 0);
    chk("reset_level", fifo_level, 0);
    idleUntil(cyc + 3);

    // Single 'w': high N+2..N+9, gap N+10..N+13, idle at N+14.
    n = cyc;
    drive(1'b0, 1'b1, 8'h77);
    chk("t1_n1_low", btnUp, 0);
    idleUntil(n + 2);  chk("t1_first_high", btnUp, 1);
    idleUntil(n + 9);  chk("t1_last_high", btnUp, 1);
    idleUntil(n + 10); chk("t1_gap_low", btnUp, 0); chk("t1_gap_busy", busy, 1);
    idleUntil(n + 13); chk("t1_gap_end_busy", busy, 1);
    idleUntil(n + 14); chk("t1_idle", busy, 0);

    // Unknown bytes are discarded.
    n = cyc;
    drive(1'b0, 1'b1, 8'h41);
    drive(1'b0, 1'b1, 8'h0D);
    drive(1'b0, 1'b1, 8'h57);
    chk("t2_level", fifo_level, 0);
    chk("t2_overflow", overflow, 0);
    idleUntil(n + 6); chk("t2_busy", busy, 0);

    // Burst during a press, then a push that coincides with the IDLE pop of a full FIFO.
    n = cyc;
    drive(1'b0, 1'b1, 8'h77);
    idleUntil(n + 3);
    for (int i = 0; i < 6; i++) begin
      if (cyc == n + 7) chk("t3_level_full", fifo_level, 4);
      if (cyc == n + 8) chk("t3_overflow_a", overflow, 1);
      drive(1'b0, 1'b1, burst[i]);
    end
    chk("t3_overflow_s", overflow, 1);
    idleUntil(n + 14);
    chk("t4_level_before", fifo_level, 4);
    drive(1'b0, 1'b1, 8'h64);
    chk("t4_level_stays", fifo_level, 4);
    chk("t4_no_overflow", overflow, 0);
    chk("t3_left_press", btnLeft, 1);
    idleUntil(n + 28); chk("t3_down_press", btnDown, 1);
    idleUntil(n + 110); chk("t3_drained", busy, 0);

    // Reset in the 3rd PRESS cycle, then a clean 's'.
    n = cyc;
    drive(1'b0, 1'b1, 8'h77);
    drive(1'b0, 1'b1, 8'h61);
    idleUntil(n + 4);
    chk("t5_pressing", btnUp, 1);
    drive(1'b1, 1'b0, 8'h00);
    chk("t5_btn_low", int'({btnAttack, btnRight, btnLeft, btnDown, btnUp}), 0);
    chk("t5_busy", busy, 0);
    chk("t5_level", fifo_level, 0);
    idleUntil(n + 8);
    n = cyc;
    drive(1'b0, 1'b1, 8'h73);
    idleUntil(n + 2);  chk("t5_s_high", btnDown, 1);
    idleUntil(n + 10); chk("t5_s_low", btnDown, 0);
    idleUntil(n + 14); chk("t5_s_idle", busy, 0);

`ifdef UART_KEY_FLUSH_EN
    n = cyc;
    drive(1'b0, 1'b1, 8'h77);
    drive(1'b0, 1'b1, 8'h61);
    drive(1'b0, 1'b1, 8'h73);
    chk("t6_level", fifo_level, 2);
    drive(1'b0, 1'b1, 8'h1B);
    chk("t6_btn_low", btnUp, 0);
    chk("t6_flushed", fifo_level, 0);
    idleUntil(n + 7); chk("t6_gap_busy", busy, 1);
    idleUntil(n + 8); chk("t6_idle", busy, 0);
    idleUntil(n + 12); chk("t6_no_press", btnLeft, 0);
`endif

    // Randomized traffic, occasional resets, then drain.
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: d = keys[$urandom_range(0, 4)];
        6:                d = 8'h1B;
        default:          d = 8'($urandom_range(0, 255));
      endcase
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) == 0), d);
    end
    idleUntil(cyc + 100);
    chk("final_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end
endmodule
